// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
//   seq_state_e  : controller state (RUN/DRAIN/SLEEP/WAKE)
//   stage_ctrl_t : per-stage-register control {en, flush}; flush dominates en
package pipe_seq_ctrl_pkg;

    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    localparam int unsigned CNT_W_DEF        = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    // Common stage-register actions
    localparam stage_ctrl_t SC_HOLD = '{en: 1'b0, flush: 1'b0};
    localparam stage_ctrl_t SC_LOAD = '{en: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t SC_NOP  = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Sequencer <-> pipeline control bundle.
//   events  : im_stall, dm_stall, load_use, fpu_busy, branch_taken, d_wfi, irq_pending
//   controls: pc_en, {fd,de,em,mw}_en, {fd,de,em}_flush, sleeping, wake_redirect, stall_cnt
// master = sequencer (drives controls), slave = pipeline/core side (drives events).
interface pipe_seq_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             im_stall;
    logic             dm_stall;
    logic             load_use;
    logic             fpu_busy;
    logic             branch_taken;
    logic             d_wfi;
    logic             irq_pending;

    logic             pc_en;
    logic             fd_en;
    logic             de_en;
    logic             em_en;
    logic             mw_en;
    logic             fd_flush;
    logic             de_flush;
    logic             em_flush;
    logic             sleeping;
    logic             wake_redirect;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  im_stall, dm_stall, load_use, fpu_busy, branch_taken, d_wfi, irq_pending,
        output pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush,
               sleeping, wake_redirect, stall_cnt
    );

    modport slave (
        output im_stall, dm_stall, load_use, fpu_busy, branch_taken, d_wfi, irq_pending,
        input  pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush,
               sleeping, wake_redirect, stall_cnt
    );
endinterface

// File: rtl/pipe_seq_ctrl_perf_cnt.sv
// Enable-gated free-running counter; wraps from all-ones to zero.
//   clk, rst_n : clock, async active-low reset
//   en         : count this cycle
//   cnt        : current count
module pipe_seq_ctrl_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Natural modular wrap of the adder gives the all-ones -> 0 rollover
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: maps stalls, hazards, FPU busy, redirects and
// WFI/interrupt events onto per-stage hold/flush controls, owns the WFI sleep
// FSM and counts stalled (non-sleep) cycles.
//   clk, rst : core clock, async active-low reset
//   bus      : pipe_seq_ctrl_if.master (events in, stage controls/status out)
// Stage controls and wake_redirect are combinational from state and events;
// state, drain counter, sleeping and stall_cnt are registered.
module pipe_seq_ctrl
    import pipe_seq_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    pipe_seq_ctrl_if.master bus
);

    localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [DRN_W-1:0] drain_q;
    logic [DRN_W-1:0] drain_d;
    logic             sleeping_q;
    logic             sleeping_d;

    logic             mem_stall_c;
    logic             pc_en_c;
    logic             wake_c;
    logic             cnt_en_c;
    stage_ctrl_t      fd_c;
    stage_ctrl_t      de_c;
    stage_ctrl_t      em_c;
    stage_ctrl_t      mw_c;
    logic [CNT_W-1:0] stall_cnt;

    assign mem_stall_c = bus.im_stall | bus.dm_stall;

    // Next-state and stage-control decode
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        pc_en_c    = 1'b0;
        wake_c     = 1'b0;
        fd_c       = SC_HOLD;
        de_c       = SC_HOLD;
        em_c       = SC_HOLD;
        mw_c       = SC_HOLD;

        case (state_q)
            ST_RUN: begin
                if (mem_stall_c) begin
                    // full freeze: defaults already hold every register
                end else if (bus.fpu_busy) begin
                    // front end holds behind the FPU op, bubble goes into E/M
                    em_c = SC_NOP;
                    mw_c = SC_LOAD;
                end else if (bus.load_use) begin
                    de_c = SC_NOP;
                    em_c = SC_LOAD;
                    mw_c = SC_LOAD;
                end else if (bus.branch_taken) begin
                    // redirect also squashes a WFI sitting in D
                    pc_en_c = 1'b1;
                    fd_c    = SC_NOP;
                    de_c    = SC_NOP;
                    em_c    = SC_LOAD;
                    mw_c    = SC_LOAD;
                end else if (bus.d_wfi) begin
                    de_c    = SC_NOP;
                    em_c    = SC_LOAD;
                    mw_c    = SC_LOAD;
                    state_d = ST_DRAIN;
                    drain_d = DRN_LOAD;
                end else begin
                    pc_en_c = 1'b1;
                    fd_c    = SC_LOAD;
                    de_c    = SC_LOAD;
                    em_c    = SC_LOAD;
                    mw_c    = SC_LOAD;
                end
            end

            ST_DRAIN: begin
                // back end retires while front end stays frozen; count only
                // advances on cycles where memory lets the pipeline move
                if (!mem_stall_c) begin
                    de_c = SC_NOP;
                    em_c = SC_LOAD;
                    mw_c = SC_LOAD;
                    if (drain_q == '0) begin
                        state_d = ST_SLEEP;
                    end else begin
                        drain_d = drain_q - DRN_W'(1);
                    end
                end
                if (bus.irq_pending) begin
                    state_d = ST_WAKE;
                end
            end

            ST_SLEEP: begin
                if (bus.irq_pending) begin
                    state_d = ST_WAKE;
                end
            end

            ST_WAKE: begin
                wake_c  = 1'b1;
                pc_en_c = 1'b1;
                fd_c    = SC_NOP;
                de_c    = SC_NOP;
                em_c    = SC_LOAD;
                mw_c    = SC_LOAD;
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign sleeping_d = (state_d == ST_SLEEP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            drain_q    <= '0;
            sleeping_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            sleeping_q <= sleeping_d;
        end
    end

    // Stall cycles exclude deliberate sleep
    assign cnt_en_c = !pc_en_c && (state_q != ST_SLEEP);

    pipe_seq_ctrl_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (cnt_en_c),
        .cnt   (stall_cnt)
    );

    assign bus.pc_en         = pc_en_c;
    assign bus.fd_en         = fd_c.en;
    assign bus.de_en         = de_c.en;
    assign bus.em_en         = em_c.en;
    assign bus.mw_en         = mw_c.en;
    assign bus.fd_flush      = fd_c.flush;
    assign bus.de_flush      = de_c.flush;
    assign bus.em_flush      = em_c.flush;
    assign bus.sleeping      = sleeping_q;
    assign bus.wake_redirect = wake_c;
    assign bus.stall_cnt     = stall_cnt;

endmodule

// File: doc/pipe_seq_ctrl.md
# pipe_seq_ctrl

Central pipeline sequencing controller for the 5-stage RV32IF core. It turns memory stalls, hazards, FPU busy, branch redirects and WFI/interrupt events into per-stage hold/flush controls for the F/D, D/E, E/M and M/W pipeline registers and the PC. It owns the WFI sleep state machine and a stall performance counter. It sits in the CPU top next to the hazard unit and drives every stage register.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles the back end keeps retiring after WFI decode before entering sleep
- CNT_W, 32, width of the stall counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- im_stall  in  1  instruction memory not ready
- dm_stall  in  1  data memory not ready
- load_use  in  1  load-use hazard detected in D
- fpu_busy  in  1  multicycle FPU op occupying E
- branch_taken  in  1  E-stage redirect
- d_wfi  in  1  WFI decoded in D
- irq_pending  in  1  enabled interrupt pending (level)
- pc_en  out  1  PC update enable
- fd_en, de_en, em_en, mw_en  out  1 each  stage register load enables
- fd_flush, de_flush, em_flush  out  1 each  load NOP into that register (flush dominates en)
- sleeping  out  1  core is in SLEEP
- wake_redirect  out  1  one-cycle pulse: fetch from interrupt/next PC
- stall_cnt  out  CNT_W  cycles with pc_en low while not in SLEEP

## Operation
- States: RUN, DRAIN, SLEEP, WAKE (2-bit encoding, reset to RUN).
- RUN control priority, highest first:
  1. im_stall|dm_stall: all en=0, all flush=0 (full freeze, registers hold).
  2. fpu_busy: pc_en=fd_en=de_en=0; em_flush=1, mw_en=1.
  3. load_use: pc_en=fd_en=0; de_flush=1; em_en=mw_en=1.
  4. branch_taken: all en=1; fd_flush=de_flush=1.
  5. d_wfi: pc_en=fd_en=0, de_flush=1, em_en=mw_en=1; next state DRAIN, drain counter loaded with DRAIN_CYCLES-1.
  6. otherwise all en=1, flushes 0.
- DRAIN: pc_en=fd_en=0, de_flush=1, em_en=mw_en=1 unless memory stalls (then freeze, counter holds). Counter decrements per non-stalled cycle; at 0 → SLEEP. irq_pending in DRAIN → WAKE directly.
- SLEEP: all en=0, sleeping=1. irq_pending → WAKE.
- WAKE: wake_redirect=1, pc_en=1, fd_flush=de_flush=1, em_en=mw_en=1; next RUN unconditionally.
- stall_cnt increments when pc_en=0 and state≠SLEEP; wraps to 0 at all-ones.

## Timing
- All enable/flush/wake_redirect outputs combinational from state and inputs, valid same cycle; state, drain counter, stall_cnt registered on posedge clk.
- Reset (rst=0, asynchronous): state=RUN, drain counter=0, stall_cnt=0, sleeping=0; combinational outputs then follow RUN rules.
- WFI to sleeping=1: 1 (d_wfi cycle) + DRAIN_CYCLES non-stalled cycles.
- irq_pending in SLEEP: wake_redirect next cycle, back in RUN the cycle after.
- Simultaneous d_wfi and branch_taken: branch wins, WFI discarded by de/fd flush.
- Simultaneous irq_pending and d_wfi in RUN: enter DRAIN; irq honoured next cycle.
- Reset mid-DRAIN/SLEEP: immediate return to RUN, counter cleared.

## Structure
- Shared core package: state typedef (RUN/DRAIN/SLEEP/WAKE), stage-control struct {en, flush}, DRAIN_CYCLES default.
- One natural sub-module: perf_cnt (enable-gated wrapping counter, CNT_W).

## Test plan
- Reset low mid-run, release → all en=1, flushes 0, stall_cnt=0, state RUN.
- dm_stall high 4 cycles with load_use and branch_taken also high → all en=0, no flush, stall_cnt +4.
- load_use 1 cycle → pc_en=fd_en=0, de_flush=1 that cycle; stall_cnt +1.
- d_wfi, no stalls, DRAIN_CYCLES=3 → sleeping=1 after 4 cycles; irq_pending → wake_redirect 1 pulse, RUN next cycle.
- d_wfi with dm_stall 2 cycles during DRAIN → sleeping delayed by exactly 2 cycles.
- stall_cnt preset near all-ones via long stall (CNT_W=4 build) → wraps 15→0.
